power_controller: RTL

POWER_CONTROLLER -- requirements
Module: power_controller

---
 rtl/power_controller.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/power_controller.sv
// Front-panel / command driven power controller: debounced button, command arbitration,
// gap/assert handshake with the downstream sequencer, timeouts, cooldown and fault latching.
module power_controller #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd100000,
    parameter logic [31:0] COOLDOWN_CYCLES = 32'd1000000,
    parameter logic [31:0] SEQ_TIMEOUT     = 32'd10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_button,
    input  logic       cmd_power_up,
    input  logic       cmd_power_down,
    input  logic       cmd_power_cycle,
    input  logic       fault,
    input  logic       fault_clear,
    input  logic       sequence_complete,
    output logic       power_up,
    output logic       power_down,
    output logic [2:0] power_state,
    output logic [1:0] fault_code
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_PWR_UP   = 3'd1,
        S_ON       = 3'd2,
        S_PWR_DOWN = 3'd3,
        S_COOLDOWN = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    localparam logic [1:0]  FC_NONE  = 2'd0;
    localparam logic [1:0]  FC_EXT   = 2'd1;
    localparam logic [1:0]  FC_UP_TO = 2'd2;
    localparam logic [1:0]  FC_DN_TO = 2'd3;
    // Counter runs 1 -> 0 during the gap, giving exactly two gap cycles.
    localparam logic [31:0] GAP_LOAD = 32'd1;

    logic [1:0]  sync_q;
    logic        btn_q, btn_d;
    logic [31:0] deb_cnt_q, deb_cnt_d;
    logic        press;

    state_t      state_q, state_d;
    logic        gap_q, gap_d;
    logic        cyc_q, cyc_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] cnt_q, cnt_d;

    logic        ev_fault, ev_down, ev_cycle, ev_up, ev_press;
    logic        seq_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b00;
            btn_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync_q    <= {sync_q[0], power_button};
            btn_q     <= btn_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // The debounced value flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        btn_d     = btn_q;
        deb_cnt_d = '0;
        press     = 1'b0;
        if (sync_q[1] != btn_q) begin
            if ((deb_cnt_q + 32'd1) >= DEBOUNCE_CYCLES) begin
                btn_d = sync_q[1];
                press = sync_q[1];
            end else begin
                deb_cnt_d = deb_cnt_q + 32'd1;
            end
        end
    end

    // Strict priority: only the single highest-priority event is visible to the FSM.
    assign ev_fault = fault;
    assign ev_down  = !fault && cmd_power_down;
    assign ev_cycle = !fault && !cmd_power_down && cmd_power_cycle;
    assign ev_up    = !fault && !cmd_power_down && !cmd_power_cycle && cmd_power_up;
    assign ev_press = !fault && !cmd_power_down && !cmd_power_cycle && !cmd_power_up && press;

    // First assert cycle is the one where the counter still holds its reload value.
    assign seq_ok = sequence_complete && (cnt_q != SEQ_TIMEOUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_OFF;
            gap_q   <= 1'b0;
            cyc_q   <= 1'b0;
            code_q  <= FC_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            cyc_q   <= cyc_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        cyc_d   = cyc_q;
        code_d  = code_q;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 32'd1;

        case (state_q)
            S_OFF: begin
                if (ev_up || ev_press || ev_cycle) state_d = S_PWR_UP;
            end
            S_PWR_UP: begin
                if (ev_fault) begin
                    state_d = S_PWR_DOWN;
                    if (code_q == FC_NONE) code_d = FC_EXT;
                end else if (ev_down) begin
                    state_d = S_PWR_DOWN;
                end else if (gap_q) begin
                    if (cnt_q == '0) begin
                        gap_d = 1'b0;
                        cnt_d = SEQ_TIMEOUT;
                    end
                end else if (seq_ok) begin
                    state_d = S_ON;
                end else if (cnt_q <= 32'd1) begin
                    state_d = S_PWR_DOWN;
                    if (code_q == FC_NONE) code_d = FC_UP_TO;
                end
            end
            S_ON: begin
                if (ev_fault) begin
                    state_d = S_PWR_DOWN;
                    if (code_q == FC_NONE) code_d = FC_EXT;
                end else if (ev_down || ev_press) begin
                    state_d = S_PWR_DOWN;
                end else if (ev_cycle) begin
                    state_d = S_PWR_DOWN;
                    cyc_d   = 1'b1;
                end
            end
            S_PWR_DOWN: begin
                if (gap_q) begin
                    if (cnt_q == '0) begin
                        gap_d = 1'b0;
                        cnt_d = SEQ_TIMEOUT;
                    end
                end else if (seq_ok) begin
                    if (code_q != FC_NONE) state_d = S_FAULT;
                    else if (cyc_q)        state_d = S_COOLDOWN;
                    else                   state_d = S_OFF;
                end else if (cnt_q <= 32'd1) begin
                    state_d = S_FAULT;
                    if (code_q == FC_NONE) code_d = FC_DN_TO;
                end
            end
            S_COOLDOWN: begin
                if (ev_fault) begin
                    state_d = S_PWR_DOWN;
                    if (code_q == FC_NONE) code_d = FC_EXT;
                end else if (ev_down) begin
                    state_d = S_OFF;
                end else if (cnt_q <= 32'd1) begin
                    state_d = S_PWR_UP;
                    cyc_d   = 1'b0;
                end
            end
            S_FAULT: begin
                if (fault_clear && !fault) begin
                    code_d  = FC_NONE;
                    state_d = S_OFF;
                end
            end
            default: state_d = S_OFF;
        endcase

        // Every state entry reloads the shared counter.
        if (state_d != state_q) begin
            gap_d = (state_d == S_PWR_UP) || (state_d == S_PWR_DOWN);
            case (state_d)
                S_PWR_UP, S_PWR_DOWN: cnt_d = GAP_LOAD;
                S_COOLDOWN:           cnt_d = COOLDOWN_CYCLES;
                default:              cnt_d = '0;
            endcase
            if ((state_d == S_OFF) || (state_d == S_FAULT)) cyc_d = 1'b0;
        end
    end

    assign power_up    = ((state_q == S_PWR_UP) && !gap_q) || (state_q == S_ON);
    assign power_down  = ((state_q == S_PWR_DOWN) && !gap_q) ||
                         ((state_q == S_FAULT) && (code_q == FC_DN_TO));
    assign power_state = state_q;
    assign fault_code  = code_q;

endmodule
